// File: rtl/jstk_spi_ctrl_pkg.sv
// Shared definitions for the PmodJSTK SPI master: FSM states, transaction size
// and where the X, Y and button fields sit inside the 40-bit received word.
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_XFER,
    ST_GAP,
    ST_FINISH
  } jstk_state_t;

  localparam int JSTK_NBYTES = 5;
  localparam int JSTK_DOUT_W = 8 * JSTK_NBYTES;

  // Byte 1 lands in [39:32] and byte 5 in [7:0]
  localparam int X_LO_MSB  = 39;
  localparam int X_LO_LSB  = 32;
  localparam int X_HI_MSB  = 25;
  localparam int X_HI_LSB  = 24;
  localparam int Y_LO_MSB  = 23;
  localparam int Y_LO_LSB  = 16;
  localparam int Y_HI_MSB  = 9;
  localparam int Y_HI_LSB  = 8;
  localparam int BTN_MSB   = 2;
  localparam int BTN_LSB   = 0;

  function automatic logic [9:0] decode_x(input logic [JSTK_DOUT_W-1:0] d);
    return {d[X_HI_MSB:X_HI_LSB], d[X_LO_MSB:X_LO_LSB]};
  endfunction

  function automatic logic [9:0] decode_y(input logic [JSTK_DOUT_W-1:0] d);
    return {d[Y_HI_MSB:Y_HI_LSB], d[Y_LO_MSB:Y_LO_LSB]};
  endfunction

  function automatic logic [2:0] decode_btn(input logic [JSTK_DOUT_W-1:0] d);
    return d[BTN_MSB:BTN_LSB];
  endfunction

endpackage

// File: rtl/jstk_spi_ctrl_if.sv
// Signal bundle between the joystick SPI master and its surroundings
// (divider clock, request/data from the car logic, SPI pins, decoded results).
interface jstk_spi_ctrl_if;
  import jstk_pkg::*;

  logic                   SCLK_IN;
  logic                   SNDREC;
  logic [7:0]             DIN;
  logic                   MISO;
  logic                   SS;
  logic                   MOSI;
  logic                   SCLK;
  logic                   BUSY;
  logic                   DONE;
  logic [JSTK_DOUT_W-1:0] DOUT;
  logic [9:0]             X;
  logic [9:0]             Y;
  logic [2:0]             BTN;

  modport master (
    input  SCLK_IN, SNDREC, DIN, MISO,
    output SS, MOSI, SCLK, BUSY, DONE, DOUT, X, Y, BTN
  );

  modport slave (
    output SCLK_IN, SNDREC, DIN, MISO,
    input  SS, MOSI, SCLK, BUSY, DONE, DOUT, X, Y, BTN
  );

endinterface

// File: rtl/jstk_spi_ctrl_edge_det.sv
// Turns the divided SPI clock into one-CLK rise/fall pulses in the system domain.
module jstk_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic SCLK_IN,
  output logic rise,
  output logic fall
);

  logic sclk_d;

  always_ff @(posedge CLK) begin
    if (RST) sclk_d <= 1'b0;
    else     sclk_d <= SCLK_IN;
  end

  assign rise = SCLK_IN & ~sclk_d;
  assign fall = ~SCLK_IN & sclk_d;

endmodule

// File: rtl/jstk_spi_ctrl.sv
// PmodJSTK SPI master (mode 0): one command byte out, five data bytes back.
// Define JSTK_DECODE_EN to get registered X/Y/BTN; otherwise they read 0.
module jstk_spi_ctrl
  import jstk_pkg::*;
#(
  parameter int NBYTES   = JSTK_NBYTES,
  parameter int INIT_PER = 1,
  parameter int GAP_PER  = 1
) (
  input  logic            CLK,
  input  logic            RST,
  jstk_spi_ctrl_if.master bus
);

  localparam int PER_MAX = (INIT_PER > GAP_PER) ? INIT_PER : GAP_PER;
  localparam int PCNT_W  = $clog2(PER_MAX) + 1;
  localparam logic [PCNT_W-1:0] INIT_LAST = PCNT_W'(INIT_PER - 1);
  localparam logic [PCNT_W-1:0] GAP_LAST  = PCNT_W'(GAP_PER - 1);
  localparam logic [2:0]        LAST_BYTE = 3'(NBYTES - 1);

  jstk_state_t            state;
  logic                   ss;
  logic                   mosi;
  logic                   sclk;
  logic                   busy;
  logic                   done;
  logic [JSTK_DOUT_W-1:0] dout;
  logic [JSTK_DOUT_W-1:0] rx_shift;
  logic [7:0]             tx_byte;
  logic [3:0]             bitcnt;
  logic [2:0]             bytecnt;
  logic [PCNT_W-1:0]      pcnt;
  logic                   rise;
  logic                   fall;

  jstk_edge_det u_edge (
    .CLK     (CLK),
    .RST     (RST),
    .SCLK_IN (bus.SCLK_IN),
    .rise    (rise),
    .fall    (fall)
  );

  // tx_byte shifts left so the next outgoing bit is always at [6] on a fall
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      ss       <= 1'b1;
      mosi     <= 1'b0;
      sclk     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
      rx_shift <= '0;
      tx_byte  <= '0;
      bitcnt   <= '0;
      bytecnt  <= '0;
      pcnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          ss   <= 1'b1;
          sclk <= 1'b0;
          if (bus.SNDREC) begin
            tx_byte  <= bus.DIN;
            rx_shift <= '0;
            bitcnt   <= '0;
            bytecnt  <= '0;
            pcnt     <= '0;
            ss       <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_INIT;
          end
        end

        ST_INIT: begin
          if (fall) begin
            if (pcnt == INIT_LAST) begin
              pcnt   <= '0;
              mosi   <= tx_byte[7];
              bitcnt <= '0;
              state  <= ST_XFER;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end

        ST_XFER: begin
          sclk <= bus.SCLK_IN;
          if (rise) begin
            rx_shift <= {rx_shift[JSTK_DOUT_W-2:0], bus.MISO};
            bitcnt   <= bitcnt + 1'b1;
          end else if (fall) begin
            if (bitcnt < 4'd8) begin
              mosi    <= tx_byte[6];
              tx_byte <= {tx_byte[6:0], 1'b0};
            end else if (bytecnt == LAST_BYTE) begin
              state <= ST_FINISH;
            end else begin
              bytecnt <= bytecnt + 1'b1;
              tx_byte <= 8'h00;
              mosi    <= 1'b0;
              pcnt    <= '0;
              state   <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          sclk <= 1'b0;
          mosi <= 1'b0;
          if (fall) begin
            if (pcnt == GAP_LAST) begin
              pcnt   <= '0;
              mosi   <= tx_byte[7];
              bitcnt <= '0;
              state  <= ST_XFER;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end

        ST_FINISH: begin
          ss    <= 1'b1;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
          dout  <= rx_shift;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SS   = ss;
  assign bus.MOSI = mosi;
  assign bus.SCLK = sclk;
  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.DOUT = dout;

`ifdef JSTK_DECODE_EN
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic [2:0] btn_q;

  // Decoded fields load from the shift register so they change with DONE
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q   <= '0;
      y_q   <= '0;
      btn_q <= '0;
    end else if (state == ST_FINISH) begin
      x_q   <= decode_x(rx_shift);
      y_q   <= decode_y(rx_shift);
      btn_q <= decode_btn(rx_shift);
    end
  end

  assign bus.X   = x_q;
  assign bus.Y   = y_q;
  assign bus.BTN = btn_q;
`else
  assign bus.X   = '0;
  assign bus.Y   = '0;
  assign bus.BTN = '0;
`endif

endmodule

// File: tb/tb_jstk_spi_ctrl.sv
// Self-checking bench for jstk_spi_ctrl with a divider model and a joystick model.
// Expects X/Y/BTN decoded only when JSTK_DECODE_EN is defined.
module tb_jstk_spi_ctrl;
  import jstk_pkg::*;

  localparam int INIT_PER = 1;
  localparam int GAP_PER  = 1;
  localparam int DIV_HALF = 5;

  typedef struct {
    logic [7:0]       din;
    logic [4:0][7:0]  resp;
    logic [39:0]      exp_dout;
    logic [9:0]       exp_x;
    logic [9:0]       exp_y;
    logic [2:0]       exp_btn;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  jstk_spi_ctrl_if bus ();

  jstk_spi_ctrl #(
    .NBYTES   (JSTK_NBYTES),
    .INIT_PER (INIT_PER),
    .GAP_PER  (GAP_PER)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Divider model: cnt_max of 4 gives a 10-CLK SCLK_IN period
  initial begin
    bus.SCLK_IN = 1'b0;
    forever begin
      repeat (DIV_HALF) @(posedge clk);
      #1 bus.SCLK_IN = ~bus.SCLK_IN;
    end
  end

  logic [39:0] jstk_bits = '0;
  logic [39:0] miso_bits = '0;
  int          miso_idx  = 0;
  logic [39:0] mosi_cap  = '0;
  int          rise_cnt  = 0;
  int          falls_since = 0;
  int          exp_falls = 0;
  int          proto_err = 0;
  int          done_cnt  = 0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_sclk_in = 1'b0, prev_mosi = 1'b0;

  // Joystick model plus protocol watcher, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) bus.MISO = 1'b0;
    if (prev_ss && !bus.SS) begin
      miso_bits   = jstk_bits;
      bus.MISO    = miso_bits[39];
      miso_idx    = 38;
      mosi_cap    = '0;
      rise_cnt    = 0;
      falls_since = 0;
    end
    if (prev_sclk && !bus.SCLK) begin
      falls_since = 0;
      if (!bus.SS && miso_idx >= 0) begin
        bus.MISO = miso_bits[miso_idx];
        miso_idx = miso_idx - 1;
      end
    end
    if (prev_sclk_in && !bus.SCLK_IN && !bus.SS) falls_since = falls_since + 1;
    if (!prev_sclk && bus.SCLK) begin
      exp_falls = (rise_cnt == 0) ? INIT_PER : ((rise_cnt % 8 == 0) ? GAP_PER : 0);
      if (falls_since != exp_falls) proto_err = proto_err + 1;
      if (bus.MOSI != prev_mosi) proto_err = proto_err + 1;
      mosi_cap = {mosi_cap[38:0], bus.MOSI};
      rise_cnt = rise_cnt + 1;
    end
    if (bus.SS && bus.SCLK) proto_err = proto_err + 1;
    if (bus.DONE) done_cnt = done_cnt + 1;
    prev_ss      = bus.SS;
    prev_sclk    = bus.SCLK;
    prev_sclk_in = bus.SCLK_IN;
    prev_mosi    = bus.MOSI;
  end

  // Reference model: the received bytes in arrival order form DOUT
  function automatic logic [39:0] model_dout(input logic [4:0][7:0] r);
    logic [39:0] d;
    d = '0;
    for (int k = 0; k < 5; k++) d = {d[31:0], r[k]};
    return d;
  endfunction

  function automatic logic [9:0] model_x(input logic [4:0][7:0] r);
`ifdef JSTK_DECODE_EN
    return {r[1][1:0], r[0]};
`else
    return (r[0] == 8'h00) ? 10'd0 : 10'd0;
`endif
  endfunction

  function automatic logic [9:0] model_y(input logic [4:0][7:0] r);
`ifdef JSTK_DECODE_EN
    return {r[3][1:0], r[2]};
`else
    return (r[2] == 8'h00) ? 10'd0 : 10'd0;
`endif
  endfunction

  function automatic logic [2:0] model_btn(input logic [4:0][7:0] r);
`ifdef JSTK_DECODE_EN
    return r[4][2:0];
`else
    return (r[4] == 8'h00) ? 3'd0 : 3'd0;
`endif
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_compared = n_compared + 1;
    if (actual !== expected) begin
      n_mismatched = n_mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.DONE) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] din, input logic [4:0][7:0] resp);
    bit started;
    started     = 1'b0;
    jstk_bits   = model_dout(resp);
    bus.DIN     = din;
    bus.SNDREC  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.BUSY) begin
        started = 1'b1;
        break;
      end
    end
    bus.SNDREC = 1'b0;
    check_output("busy_start", 64'(started), 64'd1);
  endtask

  task automatic run_txn(input vec_t v);
    int  d0, e0;
    bit  seen;
    d0 = done_cnt;
    e0 = proto_err;
    apply_stimulus(v.din, v.resp);
    wait_done(2000, seen);
    check_output("done_seen", 64'(seen), 64'd1);
    check_output("dout", 64'(bus.DOUT), 64'(v.exp_dout));
    check_output("x", 64'(bus.X), 64'(v.exp_x));
    check_output("y", 64'(bus.Y), 64'(v.exp_y));
    check_output("btn", 64'(bus.BTN), 64'(v.exp_btn));
    check_output("busy_at_done", 64'(bus.BUSY), 64'd0);
    check_output("mosi_stream", 64'(mosi_cap), 64'({v.din, 32'h0}));
    check_output("sclk_rises", 64'(rise_cnt), 64'd40);
    repeat (3) tick();
    check_output("done_pulses", 64'(done_cnt - d0), 64'd1);
    check_output("protocol", 64'(proto_err - e0), 64'd0);
  endtask

  vec_t vecs[4];
  vec_t rv;

  initial begin
    bit   seen;
    int   d0, e0;
    logic [4:0][7:0] base_resp;

    bus.SNDREC = 1'b0;
    bus.DIN    = 8'h00;

    vecs[0] = '{din: 8'h81, resp: {8'h05, 8'h01, 8'h7F, 8'h02, 8'h2C},
                exp_dout: 40'h2C027F0105, exp_x: 10'h22C, exp_y: 10'h17F, exp_btn: 3'b101};
    vecs[1] = '{din: 8'hA5, resp: {5{8'hFF}},
                exp_dout: 40'hFFFFFFFFFF, exp_x: 10'h3FF, exp_y: 10'h3FF, exp_btn: 3'b111};
    vecs[2] = '{din: 8'h3C, resp: {5{8'h00}},
                exp_dout: 40'h0, exp_x: 10'h0, exp_y: 10'h0, exp_btn: 3'b000};
    vecs[3] = '{din: 8'h5A, resp: {8'h00, 8'h02, 8'hAA, 8'h03, 8'h55},
                exp_dout: 40'h5503AA0200, exp_x: 10'h355, exp_y: 10'h2AA, exp_btn: 3'b000};
`ifndef JSTK_DECODE_EN
    for (int i = 0; i < 4; i++) begin
      vecs[i].exp_x   = '0;
      vecs[i].exp_y   = '0;
      vecs[i].exp_btn = '0;
    end
`endif

    repeat (5) tick();
    check_output("rst_ss", 64'(bus.SS), 64'd1);
    check_output("rst_sclk", 64'(bus.SCLK), 64'd0);
    check_output("rst_mosi", 64'(bus.MOSI), 64'd0);
    check_output("rst_busy", 64'(bus.BUSY), 64'd0);
    check_output("rst_done", 64'(bus.DONE), 64'd0);
    check_output("rst_dout", 64'(bus.DOUT), 64'd0);
    check_output("rst_xyb", 64'({bus.X, bus.Y, bus.BTN}), 64'd0);
    rst = 1'b0;
    repeat (3) tick();

    $display("[TB] table vectors");
    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    $display("[TB] random transactions");
    for (int i = 0; i < 6; i++) begin
      rv.din = 8'($urandom);
      for (int k = 0; k < 5; k++) rv.resp[k] = 8'($urandom);
      rv.exp_dout = model_dout(rv.resp);
      rv.exp_x    = model_x(rv.resp);
      rv.exp_y    = model_y(rv.resp);
      rv.exp_btn  = model_btn(rv.resp);
      run_txn(rv);
    end

    $display("[TB] back-to-back with SNDREC held");
    base_resp  = vecs[0].resp;
    jstk_bits  = model_dout(base_resp);
    d0         = done_cnt;
    e0         = proto_err;
    bus.DIN    = 8'hC3;
    bus.SNDREC = 1'b1;
    repeat (20) tick();
    bus.DIN = 8'h96;
    wait_done(2000, seen);
    check_output("b2b_done1", 64'(seen), 64'd1);
    check_output("b2b_mosi1", 64'(mosi_cap), 64'({8'hC3, 32'h0}));
    check_output("b2b_busy_low", 64'(bus.BUSY), 64'd0);
    tick();
    check_output("b2b_restart1", 64'(bus.BUSY), 64'd1);
    bus.DIN = 8'h3E;
    wait_done(2000, seen);
    check_output("b2b_done2", 64'(seen), 64'd1);
    check_output("b2b_mosi2", 64'(mosi_cap), 64'({8'h96, 32'h0}));
    tick();
    check_output("b2b_restart2", 64'(bus.BUSY), 64'd1);
    bus.SNDREC = 1'b0;
    bus.DIN    = 8'hEE;
    wait_done(2000, seen);
    check_output("b2b_done3", 64'(seen), 64'd1);
    check_output("b2b_mosi3", 64'(mosi_cap), 64'({8'h3E, 32'h0}));
    check_output("b2b_dout3", 64'(bus.DOUT), 64'(40'h2C027F0105));
    repeat (30) tick();
    check_output("b2b_idle", 64'(bus.BUSY), 64'd0);
    check_output("b2b_pulses", 64'(done_cnt - d0), 64'd3);
    check_output("b2b_protocol", 64'(proto_err - e0), 64'd0);

    $display("[TB] SNDREC while busy");
    d0 = done_cnt;
    apply_stimulus(8'h81, base_resp);
    repeat (100) tick();
    bus.DIN    = 8'h42;
    bus.SNDREC = 1'b1;
    tick();
    bus.SNDREC = 1'b0;
    wait_done(2000, seen);
    check_output("busy_req_done", 64'(seen), 64'd1);
    check_output("busy_req_mosi", 64'(mosi_cap), 64'({8'h81, 32'h0}));
    repeat (600) tick();
    check_output("busy_req_pulses", 64'(done_cnt - d0), 64'd1);
    check_output("busy_req_idle", 64'(bus.BUSY), 64'd0);

    $display("[TB] reset during byte 3");
    apply_stimulus(8'h81, base_resp);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (rise_cnt >= 17) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("mid_reached_byte3", 64'(seen), 64'd1);
    d0  = done_cnt;
    rst = 1'b1;
    tick();
    check_output("mid_rst_ss", 64'(bus.SS), 64'd1);
    check_output("mid_rst_sclk", 64'(bus.SCLK), 64'd0);
    check_output("mid_rst_busy", 64'(bus.BUSY), 64'd0);
    check_output("mid_rst_dout", 64'(bus.DOUT), 64'd0);
    check_output("mid_rst_done", 64'(bus.DONE), 64'd0);
    rst = 1'b0;
    repeat (600) tick();
    check_output("mid_no_done", 64'(done_cnt - d0), 64'd0);
    run_txn(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
